host_cnf_streamer: RTL and testbench
====================================

// Module: host_cnf_streamer
// PURPOSE
// Host-side driver for the SatSwarm load/control port; it is the transmitter matching the solver's CNF load receiver.
// Accepts a DIMACS-style token stream (nonzero literals, 0 = clause terminator) and converts it into
// literal beats with an in-band clause_end flag. After the last clause, pulses start and waits for done,
// then latches the SAT/UNSAT/timeout result. Sits between the host command path and satswarm_top.
// PARAMETERS
// LIT_W      32    literal width (signed)
// CNT_W      32    width of cycle/clause/literal counters
// MAX_LITS   2048  literal capacity per core; exceeding it is an error
// START_GAP  4     idle cycles between final load beat accepted and start pulse
// PORTS
// clk              in   1      clock
// rst              in   1      synchronous reset, active-high
// cfg_go           in   1      begin a run; honoured only in IDLE/DONE/ERROR
// cfg_timeout      in   CNT_W  solve-cycle limit, sampled on cfg_go; 0 = unlimited
// src_valid        in   1      token valid
// src_literal      in   LIT_W  signed token; 0 terminates current clause
// src_last         in   1      marks final token of formula
// src_ready        out  1      token accepted when src_valid&&src_ready
// load_valid       out  1      to host_load_valid
// load_literal     out  LIT_W  to host_load_literal
// load_clause_end  out  1      to host_load_clause_end
// load_ready       in   1      from host_load_ready
// solve_start      out  1      one-cycle pulse to host_start
// solve_done/solve_sat/solve_unsat  in 1 each   from host_done/host_sat/host_unsat (levels)
// busy             out  1      state not in IDLE/DONE/ERROR
// result_valid     out  1      held high in DONE/ERROR until next cfg_go
// result_sat/result_unsat/result_timeout  out 1 each   latched outcome
// err_code         out  2      0 none,1 EMPTY_CLAUSE,2 UNTERMINATED,3 LIT_OVERFLOW
// clause_count     out  CNT_W  clauses emitted this run
// cycle_count      out  CNT_W  cycles spent in SOLVE
// BEHAVIOUR
// - Reset: state IDLE; every output 0; pending/output registers invalid; counters 0.
// - States: IDLE -go-> LOAD -last processed-> DRAIN -out empty-> GAP(START_GAP cyc) -> START(1 cyc) -> SOLVE -> DONE;
//   any error -> ERROR. cfg_go in DONE/ERROR clears results and counters, enters LOAD.
// - Datapath: pend reg holds last nonzero literal not yet emitted; out reg drives load_*, held stable until load_ready.
// - out_free = !load_valid || load_ready. src_ready = (state==LOAD) && (!pend_valid || out_free).
// - Nonzero token L: if pend_valid, out<={pend,clause_end=0}; pend<=L. Zero token: pend_valid ? out<={pend,1},
//   pend_valid<=0, clause_count++ : error EMPTY_CLAUSE.
// - Literal count (beats emitted) > MAX_LITS -> LIT_OVERFLOW; beat that would exceed is not emitted.
// - src_last accepted with pend_valid remaining after processing (last token nonzero) -> UNTERMINATED.
// - Latency: literal emitted on load_* the cycle after its successor token is accepted; full throughput 1 beat/cycle.
// - DRAIN: src_ready=0; leave when load_valid==0 (last beat consumed).
// - SOLVE: cycle_count++ each cycle. solve_done high -> latch sat/unsat, DONE. Else if cfg_timeout!=0 and
//   cycle_count+1==cfg_timeout -> result_timeout=1, DONE. done and timeout same cycle: done wins.
// - ERROR: load_valid dropped immediately (beat in flight discarded), err_code latched, result_valid=1.
// - cfg_go while busy is ignored. rst mid-run returns to IDLE within one cycle, no start pulse emitted.
// - solve_sat and solve_unsat both high: latch both, err_code stays 0 (checker flags it).
// STRUCTURE
// - satswarmv2_pkg: streamer_state_e enum, stream_err_e (2-bit) codes, ERR_* constants.
// - Single module; pend/out pair kept inline. No sub-module required.
// TESTING
// - Tokens 1,-2,0,3,0(last), load_ready=1 -> beats (1,0),(-2,1),(3,1); clause_count=2; solve_start once 5 cyc after last beat.
// - Same stream, load_ready toggling 1010 -> identical beat sequence, no drops/dups, load_* stable while stalled.
// - Tokens 1,0,0 -> ERROR, err_code=1, result_valid=1, no solve_start.
// - Tokens 4,5(last) -> err_code=2; MAX_LITS=2, tokens 1,2,3,0 -> err_code=3, only 2 beats emitted.
// - cfg_timeout=10, solve_done never -> result_timeout=1, cycle_count=10; done at cycle 10 -> sat wins, timeout=0.
// - rst asserted mid-LOAD, then cfg_go with fresh stream -> clean run, counters restart at 0.

Source files
------------

// File: rtl/satswarmv2_pkg.sv
// Shared definitions for the SatSwarm host-side CNF streamer.
//   - FSM state encodings (3-bit localparam constants)
//   - stream_err_e: 2-bit error codes reported on err_code
package satswarmv2_pkg;

  typedef logic [2:0] streamer_state_e;

  localparam streamer_state_e ST_IDLE  = 3'd0;
  localparam streamer_state_e ST_LOAD  = 3'd1;
  localparam streamer_state_e ST_DRAIN = 3'd2;
  localparam streamer_state_e ST_GAP   = 3'd3;
  localparam streamer_state_e ST_START = 3'd4;
  localparam streamer_state_e ST_SOLVE = 3'd5;
  localparam streamer_state_e ST_DONE  = 3'd6;
  localparam streamer_state_e ST_ERROR = 3'd7;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_EMPTY_CLAUSE = 2'd1,
    ERR_UNTERMINATED = 2'd2,
    ERR_LIT_OVERFLOW = 2'd3
  } stream_err_e;

  // True for states in which a new run may be launched with cfg_go.
  function automatic logic is_idle_like(input streamer_state_e st);
    return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR);
  endfunction

endpackage

// File: rtl/host_cnf_streamer.sv
// Host-side transmitter for the SatSwarm CNF load/control port.
// Converts a DIMACS-style token stream (nonzero literal, 0 = end of clause)
// into literal beats with an in-band clause_end flag, then pulses solve_start
// and waits for the solver to finish (or time out) and latches the outcome.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cfg_go, cfg_timeout          launch a run; solve-cycle limit (0 = none)
//   src_valid/literal/last/ready token input handshake
//   load_valid/literal/clause_end/ready   beat output to the solver
//   solve_start                  one-cycle start pulse
//   solve_done/sat/unsat         solver status levels
//   busy, result_valid, result_sat/unsat/timeout, err_code
//   clause_count, cycle_count    per-run statistics
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for cfg_go
// LOAD     | accepting tokens, emitting beats
// DRAIN    | last token processed, waiting for final beat to be taken
// GAP      | START_GAP idle cycles before the start pulse
// START    | solve_start high for one cycle
// SOLVE    | counting cycles, waiting for done or timeout
// DONE     | result latched, result_valid high
// ERROR    | stream error latched, result_valid high
module host_cnf_streamer
  import satswarmv2_pkg::*;
#(
  parameter int LIT_W     = 32,
  parameter int CNT_W     = 32,
  parameter int MAX_LITS  = 2048,
  parameter int START_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_go,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic             src_valid,
  input  logic [LIT_W-1:0] src_literal,
  input  logic             src_last,
  output logic             src_ready,
  output logic             load_valid,
  output logic [LIT_W-1:0] load_literal,
  output logic             load_clause_end,
  input  logic             load_ready,
  output logic             solve_start,
  input  logic             solve_done,
  input  logic             solve_sat,
  input  logic             solve_unsat,
  output logic             busy,
  output logic             result_valid,
  output logic             result_sat,
  output logic             result_unsat,
  output logic             result_timeout,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] clause_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int GAP_W = (START_GAP > 2) ? $clog2(START_GAP) : 1;

  streamer_state_e  state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic             pend_valid_q, pend_valid_d;
  logic [LIT_W-1:0] pend_lit_q, pend_lit_d;
  logic             out_valid_q, out_valid_d;
  logic [LIT_W-1:0] out_lit_q, out_lit_d;
  logic             out_end_q, out_end_d;

  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] lit_count_q, lit_count_d;
  logic [CNT_W-1:0] clause_count_q, clause_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic             res_sat_q, res_sat_d;
  logic             res_unsat_q, res_unsat_d;
  logic             res_timeout_q, res_timeout_d;
  stream_err_e      err_q, err_d;

  logic             out_free;
  logic             accept;
  logic             want_emit;
  logic             emit_end;
  logic             raise;
  stream_err_e      raise_code;

  assign out_free  = !out_valid_q || load_ready;
  assign src_ready = (state_q == ST_LOAD) && (!pend_valid_q || out_free);
  assign accept    = src_valid && src_ready;

  always_comb begin
    state_d        = state_q;
    gap_cnt_d      = gap_cnt_q;
    pend_valid_d   = pend_valid_q;
    pend_lit_d     = pend_lit_q;
    out_valid_d    = out_valid_q;
    out_lit_d      = out_lit_q;
    out_end_d      = out_end_q;
    timeout_d      = timeout_q;
    lit_count_d    = lit_count_q;
    clause_count_d = clause_count_q;
    cycle_count_d  = cycle_count_q;
    res_sat_d      = res_sat_q;
    res_unsat_d    = res_unsat_q;
    res_timeout_d  = res_timeout_q;
    err_d          = err_q;
    want_emit      = 1'b0;
    emit_end       = 1'b0;
    raise          = 1'b0;
    raise_code     = ERR_NONE;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (cfg_go) begin
          state_d        = ST_LOAD;
          timeout_d      = cfg_timeout;
          pend_valid_d   = 1'b0;
          out_valid_d    = 1'b0;
          lit_count_d    = '0;
          clause_count_d = '0;
          cycle_count_d  = '0;
          res_sat_d      = 1'b0;
          res_unsat_d    = 1'b0;
          res_timeout_d  = 1'b0;
          err_d          = ERR_NONE;
        end
      end

      ST_LOAD: begin
        if (out_valid_q && load_ready) out_valid_d = 1'b0;
        if (accept) begin
          if (src_literal != '0) begin
            want_emit    = pend_valid_q;
            emit_end     = 1'b0;
            pend_lit_d   = src_literal;
            pend_valid_d = 1'b1;
          end else if (pend_valid_q) begin
            want_emit    = 1'b1;
            emit_end     = 1'b1;
            pend_valid_d = 1'b0;
          end else begin
            raise      = 1'b1;
            raise_code = ERR_EMPTY_CLAUSE;
          end

          // Only emit when the output register is free; src_ready already
          // guarantees that whenever a pending literal exists.
          if (want_emit) begin
            if (lit_count_q >= CNT_W'(MAX_LITS)) begin
              raise      = 1'b1;
              raise_code = ERR_LIT_OVERFLOW;
            end else begin
              out_valid_d = 1'b1;
              out_lit_d   = pend_lit_q;
              out_end_d   = emit_end;
              lit_count_d = lit_count_q + 1'b1;
              if (emit_end) clause_count_d = clause_count_q + 1'b1;
            end
          end

          if (!raise && src_last) begin
            if (pend_valid_d) begin
              raise      = 1'b1;
              raise_code = ERR_UNTERMINATED;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end

        // Any beat produced or still in flight is discarded on error.
        if (raise) begin
          state_d      = ST_ERROR;
          err_d        = raise_code;
          out_valid_d  = 1'b0;
          pend_valid_d = 1'b0;
        end
      end

      ST_DRAIN: begin
        if (out_valid_q && load_ready) out_valid_d = 1'b0;
        // The cycle that retires the final beat is not itself an idle cycle,
        // so GAP alone supplies all START_GAP idle cycles.
        if (!out_valid_d) begin
          if (START_GAP == 0) begin
            state_d = ST_START;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_W'(START_GAP - 1);
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_START;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end

      ST_START: begin
        state_d = ST_SOLVE;
      end

      ST_SOLVE: begin
        cycle_count_d = cycle_count_q + 1'b1;
        if (solve_done) begin
          res_sat_d   = solve_sat;
          res_unsat_d = solve_unsat;
          state_d     = ST_DONE;
        end else if ((timeout_q != '0) && (cycle_count_d == timeout_q)) begin
          res_timeout_d = 1'b1;
          state_d       = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      gap_cnt_q      <= '0;
      pend_valid_q   <= 1'b0;
      pend_lit_q     <= '0;
      out_valid_q    <= 1'b0;
      out_lit_q      <= '0;
      out_end_q      <= 1'b0;
      timeout_q      <= '0;
      lit_count_q    <= '0;
      clause_count_q <= '0;
      cycle_count_q  <= '0;
      res_sat_q      <= 1'b0;
      res_unsat_q    <= 1'b0;
      res_timeout_q  <= 1'b0;
      err_q          <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      pend_valid_q   <= pend_valid_d;
      pend_lit_q     <= pend_lit_d;
      out_valid_q    <= out_valid_d;
      out_lit_q      <= out_lit_d;
      out_end_q      <= out_end_d;
      timeout_q      <= timeout_d;
      lit_count_q    <= lit_count_d;
      clause_count_q <= clause_count_d;
      cycle_count_q  <= cycle_count_d;
      res_sat_q      <= res_sat_d;
      res_unsat_q    <= res_unsat_d;
      res_timeout_q  <= res_timeout_d;
      err_q          <= err_d;
    end
  end

  assign load_valid      = out_valid_q;
  assign load_literal    = out_lit_q;
  assign load_clause_end = out_end_q;
  assign solve_start     = (state_q == ST_START);
  assign busy            = !is_idle_like(state_q);
  assign result_valid    = (state_q == ST_DONE) || (state_q == ST_ERROR);
  assign result_sat      = res_sat_q;
  assign result_unsat    = res_unsat_q;
  assign result_timeout  = res_timeout_q;
  assign err_code        = err_q;
  assign clause_count    = clause_count_q;
  assign cycle_count     = cycle_count_q;

endmodule

// File: tb/tb_host_cnf_streamer.sv
module tb_host_cnf_streamer;

  localparam int LIT_W = 32;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_go = 1'b0;
  logic [CNT_W-1:0] cfg_timeout = '0;
  logic             src_valid = 1'b0;
  logic [LIT_W-1:0] src_literal = '0;
  logic             src_last = 1'b0;
  logic             src_ready;
  logic             load_valid;
  logic [LIT_W-1:0] load_literal;
  logic             load_clause_end;
  logic             load_ready = 1'b1;
  logic             solve_start;
  logic             solve_done = 1'b0;
  logic             solve_sat = 1'b0;
  logic             solve_unsat = 1'b0;
  logic             busy;
  logic             result_valid;
  logic             result_sat;
  logic             result_unsat;
  logic             result_timeout;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] clause_count;
  logic [CNT_W-1:0] cycle_count;

  // MAX_LITS=3 lets the 3-beat formula hit the limit exactly and a
  // 4-literal clause overflow it.
  host_cnf_streamer #(
    .LIT_W(LIT_W), .CNT_W(CNT_W), .MAX_LITS(3), .START_GAP(4)
  ) dut (
    .clk(clk), .rst(rst), .cfg_go(cfg_go), .cfg_timeout(cfg_timeout),
    .src_valid(src_valid), .src_literal(src_literal), .src_last(src_last),
    .src_ready(src_ready), .load_valid(load_valid), .load_literal(load_literal),
    .load_clause_end(load_clause_end), .load_ready(load_ready),
    .solve_start(solve_start), .solve_done(solve_done), .solve_sat(solve_sat),
    .solve_unsat(solve_unsat), .busy(busy), .result_valid(result_valid),
    .result_sat(result_sat), .result_unsat(result_unsat),
    .result_timeout(result_timeout), .err_code(err_code),
    .clause_count(clause_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LIT_W-1:0] lit;
    logic             ce;
  } beat_t;

  beat_t      exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         start_cnt = 0;
  int         start_cyc = 0;
  int         last_beat_cyc = 0;
  logic       tog_en = 1'b0;
  logic       stall_prev = 1'b0;
  logic [LIT_W-1:0] stall_lit;
  logic       stall_ce;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (tog_en) load_ready = ~load_ready;
  end

  // Monitor: pops the scoreboard on every accepted beat, checks that a
  // stalled beat holds steady, and records start pulses.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        total++;
        if (!load_valid || load_literal !== stall_lit || load_clause_end !== stall_ce) begin
          bad++;
          $display("FAIL stall_hold got v=%0b lit=%0d ce=%0b want v=1 lit=%0d ce=%0b",
                   load_valid, $signed(load_literal), load_clause_end,
                   $signed(stall_lit), stall_ce);
        end
      end
      stall_prev = load_valid && !load_ready;
      stall_lit  = load_literal;
      stall_ce   = load_clause_end;
      if (load_valid && load_ready) begin
        total++;
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got lit=%0d ce=%0b want none",
                   $signed(load_literal), load_clause_end);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          if (load_literal !== b.lit || load_clause_end !== b.ce) begin
            bad++;
            $display("FAIL beat got lit=%0d ce=%0b want lit=%0d ce=%0b",
                     $signed(load_literal), load_clause_end, $signed(b.lit), b.ce);
          end
        end
      end
      if (solve_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int lit, input bit ce);
    beat_t b;
    b.lit = lit;
    b.ce  = ce;
    exp_q.push_back(b);
  endtask

  task automatic go(input int unsigned tmo);
    cfg_timeout = tmo;
    cfg_go = 1'b1;
    @(posedge clk); #1;
    cfg_go = 1'b0;
  endtask

  task automatic send(input int lit, input bit last);
    bit acc;
    acc = 1'b0;
    src_valid   = 1'b1;
    src_literal = lit;
    src_last    = last;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (src_ready) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("token_accepted", {63'd0, acc}, 64'd1);
    if (acc) begin
      @(posedge clk); #1;
    end
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (solve_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("start_seen", {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
  endtask

  // Called just after the first SOLVE edge: drives done during SOLVE cycle k.
  task automatic respond(input int k, input bit sat, input bit unsat);
    repeat (k - 1) @(posedge clk);
    #1;
    solve_done = 1'b1; solve_sat = sat; solve_unsat = unsat;
    @(posedge clk); #1;
    solve_done = 1'b0; solve_sat = 1'b0; solve_unsat = 1'b0;
  endtask

  task automatic wait_result();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("result_seen", {63'd0, seen}, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_res(input int err, input bit sat, input bit unsat,
                           input bit to, input int clauses, input int cycles);
    chk("err_code", 64'(err_code), 64'(err));
    chk("result_sat", 64'(result_sat), 64'(sat));
    chk("result_unsat", 64'(result_unsat), 64'(unsat));
    chk("result_timeout", 64'(result_timeout), 64'(to));
    chk("clause_count", 64'(clause_count), 64'(clauses));
    chk("cycle_count", 64'(cycle_count), 64'(cycles));
    chk("busy_after", 64'(busy), 64'd0);
    chk("beats_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int s0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_load_valid", 64'(load_valid), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_start", 64'(solve_start), 64'd0);
    chk("rst_err", 64'(err_code), 64'd0);
    chk("rst_clauses", 64'(clause_count), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic formula, load_ready held high
    s0 = start_cnt;
    go(0);
    push(1, 0); push(-2, 1); push(3, 1);
    send(1, 0); send(-2, 0); send(0, 0); send(3, 0); send(0, 1);
    wait_start();
    chk("start_gap", 64'(start_cyc - last_beat_cyc), 64'd5);
    respond(3, 1, 0);
    wait_result();
    check_res(0, 1, 0, 0, 2, 3);
    chk("start_once", 64'(start_cnt - s0), 64'd1);

    // same formula with load_ready toggling
    s0 = start_cnt;
    go(0);
    tog_en = 1'b1;
    push(1, 0); push(-2, 1); push(3, 1);
    send(1, 0); send(-2, 0); send(0, 0); send(3, 0); send(0, 1);
    wait_start();
    tog_en = 1'b0;
    load_ready = 1'b1;
    chk("start_gap_stall", 64'(start_cyc - last_beat_cyc), 64'd5);
    respond(2, 0, 1);
    wait_result();
    check_res(0, 0, 1, 0, 2, 2);
    chk("start_once_stall", 64'(start_cnt - s0), 64'd1);

    // empty clause
    s0 = start_cnt;
    go(0);
    push(1, 1);
    send(1, 0); send(0, 0); send(0, 0);
    wait_result();
    check_res(1, 0, 0, 0, 1, 0);
    repeat (8) @(posedge clk); #1;
    chk("no_start_empty", 64'(start_cnt - s0), 64'd0);

    // unterminated final clause: in-flight beat is discarded
    go(0);
    send(4, 0); send(5, 1);
    wait_result();
    check_res(2, 0, 0, 0, 0, 0);
    chk("load_valid_err", 64'(load_valid), 64'd0);

    // literal overflow at MAX_LITS=3
    go(0);
    push(1, 0); push(2, 0); push(3, 0);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0); send(0, 0);
    wait_result();
    check_res(3, 0, 0, 0, 0, 0);

    // timeout with no done
    go(10);
    push(5, 1);
    send(5, 0); send(0, 1);
    wait_start();
    wait_result();
    check_res(0, 0, 0, 1, 1, 10);

    // done on the timeout cycle: done wins
    go(10);
    push(6, 1);
    send(6, 0); send(0, 1);
    wait_start();
    respond(10, 1, 0);
    wait_result();
    check_res(0, 1, 0, 0, 1, 10);

    // sat and unsat together, cfg_go while busy ignored
    go(0);
    push(-7, 1);
    send(-7, 0); send(0, 1);
    wait_start();
    cfg_go = 1'b1;
    @(posedge clk); #1;
    cfg_go = 1'b0;
    chk("busy_ignores_go", 64'(busy), 64'd1);
    respond(1, 1, 1);
    wait_result();
    check_res(0, 1, 1, 0, 1, 2);

    // reset mid-LOAD, then a clean run
    s0 = start_cnt;
    go(0);
    push(1, 1);
    send(1, 0); send(0, 0); send(2, 0);
    chk("pre_rst_clauses", 64'(clause_count), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_clauses", 64'(clause_count), 64'd0);
    chk("rst_mid_load_valid", 64'(load_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("no_start_rst", 64'(start_cnt - s0), 64'd0);
    go(0);
    push(7, 1);
    send(7, 0); send(0, 1);
    wait_start();
    respond(1, 1, 0);
    wait_result();
    check_res(0, 1, 0, 0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
